// File: rtl/gray_pkg.sv
// Shared mode encodings and Gray/binary conversion helpers for the gray codec.
// The helpers work on 32-bit values; callers zero-extend and truncate to their width.
package gray_pkg;

   localparam int unsigned MODE_W = 2;
   localparam int unsigned MAX_W  = 32;

   localparam logic [MODE_W-1:0] MODE_B2G = 2'd0;
   localparam logic [MODE_W-1:0] MODE_G2B = 2'd1;
   localparam logic [MODE_W-1:0] MODE_CNT = 2'd2;
   localparam logic [MODE_W-1:0] MODE_CHK = 2'd3;

   function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Zero upper bits leave the prefix XOR unchanged, so narrower codes convert correctly.
   function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
      logic [MAX_W-1:0] b;
      b           = '0;
      b[MAX_W-1]  = g[MAX_W-1];
      for (int i = MAX_W - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/gray_step_check.sv
// Flags a Gray-code step violation: the current code must differ from the
// previous one in exactly one bit, and only once a previous code exists.
module gray_step_check #(
   parameter int unsigned WIDTH = 4
) (
   input  logic [WIDTH-1:0] cur,
   input  logic [WIDTH-1:0] prev,
   input  logic             prev_valid,
   output logic             err
);

   logic [WIDTH-1:0] diff;
   logic             single_bit;

   // A value is a single set bit when it is nonzero and clearing its lowest set bit leaves zero.
   always_comb begin
      diff       = cur ^ prev;
      single_bit = (diff != '0) && ((diff & (diff - WIDTH'(1))) == '0);
      err        = prev_valid && !single_bit;
   end

endmodule

// File: rtl/gray_codec.sv
// Single-stage Gray codec: converts, counts or checks Gray codes with a
// one-cycle valid/ready output register.
module gray_codec
   import gray_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [MODE_W-1:0] mode,
   input  logic              clr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  out_data,
   output logic              out_err
);

   logic             accept;
   logic             chk_err;
   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] prev;
   logic             prev_valid;

   logic             nxt_valid;
   logic [WIDTH-1:0] nxt_data;
   logic             nxt_err;
   logic [WIDTH-1:0] nxt_cnt;
   logic [WIDTH-1:0] nxt_prev;
   logic             nxt_pv;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   // A clear in the same cycle makes this sample the first of a new history.
   gray_step_check #(.WIDTH(WIDTH)) u_step_check (
      .cur        (in_data),
      .prev       (prev),
      .prev_valid (prev_valid && !clr),
      .err        (chk_err)
   );

   always_comb begin
      nxt_valid = out_valid;
      nxt_data  = out_data;
      nxt_err   = out_err;
      nxt_cnt   = clr ? '0 : cnt;
      nxt_prev  = prev;
      nxt_pv    = prev_valid && !clr;

      if (accept) begin
         nxt_valid = 1'b1;
         nxt_err   = 1'b0;
         case (mode)
            MODE_B2G: nxt_data = WIDTH'(bin2gray(MAX_W'(in_data)));
            MODE_G2B: nxt_data = WIDTH'(gray2bin(MAX_W'(in_data)));
            MODE_CNT: begin
               nxt_data = WIDTH'(bin2gray(MAX_W'(nxt_cnt)));
               nxt_cnt  = nxt_cnt + WIDTH'(1);
            end
            default: begin
               nxt_data = WIDTH'(gray2bin(MAX_W'(in_data)));
               nxt_err  = chk_err;
               nxt_prev = in_data;
               nxt_pv   = 1'b1;
            end
         endcase
      end else if (out_ready) begin
         nxt_valid = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_err    <= 1'b0;
         cnt        <= '0;
         prev       <= '0;
         prev_valid <= 1'b0;
      end else begin
         out_valid  <= nxt_valid;
         out_data   <= nxt_data;
         out_err    <= nxt_err;
         cnt        <= nxt_cnt;
         prev       <= nxt_prev;
         prev_valid <= nxt_pv;
      end
   end

endmodule

// File: tb/tb_gray_codec.sv
// Self-checking bench for gray_codec (WIDTH=4): directed vectors plus random
// traffic compared against a cycle-level behavioural model.
module tb_gray_codec;

   localparam int unsigned W = 4;
   localparam int unsigned N = 16;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [1:0]   mode = 2'd0;
   logic         clr = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_data = '0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] out_data;
   logic         out_err;

   gray_codec #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode      (mode),
      .clr       (clr),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_err   (out_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model state
   bit         m_valid = 0;
   int         m_data  = 0;
   bit         m_err   = 0;
   int         m_cnt   = 0;
   int         m_prev  = 0;
   bit         m_pv    = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int gray_of(input int n);
      return (n ^ (n / 2)) % N;
   endfunction

   // Inverse by search: the binary value whose Gray code matches.
   function automatic int bin_of(input int g);
      for (int b = 0; b < N; b++) begin
         if (gray_of(b) == g) return b;
      end
      return -1;
   endfunction

   function automatic int popc(input int v);
      int c = 0;
      for (int i = 0; i < 32; i++) c += (v >> i) & 1;
      return c;
   endfunction

   // One clock cycle, entered and left at the falling edge.
   task automatic cycle(input bit v, input int md, input int d, input bit c,
                        input bit ordy, input bit rs);
      bit acc;
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) begin
         chk("out_data", 32'(out_data), 32'(m_data));
         chk("out_err", 32'(out_err), 32'(m_err));
      end
      rst_n     = rs;
      in_valid  = v;
      mode      = 2'(md);
      in_data   = W'(d);
      clr       = c;
      out_ready = ordy;
      #1;
      chk("in_ready", 32'(in_ready), 32'(!m_valid || ordy));
      acc = v && (!m_valid || ordy);
      if (!rs) begin
         m_valid = 0; m_data = 0; m_err = 0; m_cnt = 0; m_prev = 0; m_pv = 0;
      end else begin
         if (acc) begin
            m_valid = 1;
            m_err   = 0;
            case (md)
               0: m_data = gray_of(d);
               1: m_data = bin_of(d);
               2: begin
                  if (c) m_cnt = 0;
                  m_data = gray_of(m_cnt);
                  m_cnt  = (m_cnt + 1) % N;
               end
               default: begin
                  m_data = bin_of(d);
                  m_err  = m_pv && !c && (popc(d ^ m_prev) != 1);
                  m_prev = d;
                  m_pv   = 1;
               end
            endcase
         end else if (ordy) begin
            m_valid = 0;
         end
         if (c && !(acc && md == 2)) m_cnt = 0;
         if (c && !(acc && md == 3)) m_pv = 0;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      int g;
      int chk_in[6]  = '{0, 1, 3, 7, 4, 4};
      int chk_err[6] = '{0, 0, 0, 0, 1, 1};

      @(negedge clk);
      cycle(0, 0, 0, 0, 1, 0);
      cycle(0, 0, 0, 0, 1, 0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_data", 32'(out_data), 32'd0);
      chk("rst_err", 32'(out_err), 32'd0);
      chk("rst_ready", 32'(in_ready), 32'd1);

      cycle(1, 0, 4'b1011, 0, 1, 1);
      chk("b2g_1011", 32'(out_data), 32'hE);
      chk("b2g_err", 32'(out_err), 32'd0);
      cycle(1, 1, 4'b1110, 0, 1, 1);
      chk("g2b_1110", 32'(out_data), 32'hB);

      for (int i = 0; i < N; i++) begin
         cycle(1, 0, i, 0, 1, 1);
         g = int'(out_data);
         cycle(1, 1, g, 0, 1, 1);
         chk("roundtrip", 32'(out_data), 32'(i));
      end

      cycle(0, 0, 0, 0, 1, 0);
      for (int k = 0; k <= N; k++) begin
         cycle(1, 2, int'($urandom % N), 0, 1, 1);
         chk("cnt_seq", 32'(out_data), 32'(gray_of(k % N)));
      end
      cycle(1, 2, 0, 0, 1, 1);
      cycle(1, 2, 0, 0, 1, 1);
      cycle(1, 2, 0, 1, 1, 1);
      chk("cnt_clr_acc", 32'(out_data), 32'd0);
      cycle(1, 2, 0, 0, 1, 1);
      chk("cnt_after_clr", 32'(out_data), 32'd1);
      cycle(0, 0, 0, 1, 1, 1);
      cycle(1, 2, 0, 0, 1, 1);
      chk("cnt_clr_idle", 32'(out_data), 32'd0);

      cycle(0, 0, 0, 1, 1, 1);
      for (int i = 0; i < 6; i++) begin
         cycle(1, 3, chk_in[i], 0, 1, 1);
         chk("chk_err_seq", 32'(out_err), 32'(chk_err[i]));
      end
      cycle(1, 3, 4'hF, 1, 1, 1);
      chk("chk_clr_first", 32'(out_err), 32'd0);
      chk("chk_clr_data", 32'(out_data), 32'hA);
      cycle(1, 2, 0, 0, 1, 1);
      chk("mode2_err", 32'(out_err), 32'd0);

      cycle(1, 0, 4'h5, 0, 1, 1);
      for (int i = 0; i < 3; i++) begin
         cycle(1, 0, 4'h9, 0, 0, 1);
         chk("stall_ready", 32'(in_ready), 32'd0);
         chk("stall_data", 32'(out_data), 32'h7);
      end
      cycle(1, 0, 4'h9, 0, 1, 1);
      chk("release_data", 32'(out_data), 32'hD);
      cycle(0, 0, 0, 0, 1, 1);
      chk("drain_valid", 32'(out_valid), 32'd0);

      cycle(0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 6; i++) cycle(1, 2, 0, 0, 1, 1);
      chk("pre_rst_valid", 32'(out_valid), 32'd1);
      cycle(1, 2, 0, 1, 0, 0);
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_data", 32'(out_data), 32'd0);
      cycle(1, 2, 0, 0, 1, 1);
      chk("post_rst_cnt", 32'(out_data), 32'd0);

      for (int i = 0; i < 2000; i++) begin
         cycle(($urandom % 4) != 0, int'($urandom % 4), int'($urandom % N),
               ($urandom % 16) == 0, ($urandom % 4) != 0, ($urandom % 64) != 0);
      end
      cycle(0, 0, 0, 0, 1, 1);
      cycle(0, 0, 0, 0, 1, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/gray_codec.md
GRAY_CODEC -- requirements
Module: gray_codec

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, code width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 mode  input  2  operation select, sampled only on an accepted input; 0 bin2gray, 1 gray2bin, 2 gray count, 3 gray check.
REQ-005 clr  input  1  synchronous clear of the counter and checker history; does not touch the output register.
REQ-006 in_valid  input  1  in_data/mode valid this cycle.
REQ-007 in_ready  output  1  block can accept input this cycle.
REQ-008 in_data  input  WIDTH  operand; ignored in mode 2.
REQ-009 out_valid  output  1  out_data/out_err valid.
REQ-010 out_ready  input  1  downstream accepts the output this cycle.
REQ-011 out_data  output  WIDTH  result.
REQ-012 out_err  output  1  gray-step violation flag; meaningful only in mode 3, else 0.

Function
REQ-013 in_ready SHALL equal (!out_valid || out_ready), combinationally; accept = in_valid && in_ready.
REQ-014 Latency SHALL be 1 cycle: accept at edge N gives out_valid=1 with result after edge N; throughput 1 per cycle under out_ready=1.
REQ-015 With no accept and out_ready=1, out_valid SHALL clear at the next edge; with out_valid=1 and out_ready=0, out_data/out_err SHALL hold stable.
REQ-016 Mode 0: out_data = in_data ^ (in_data >> 1).
REQ-017 Mode 1: out_data[WIDTH-1] = in_data[WIDTH-1]; out_data[i] = out_data[i+1] ^ in_data[i] for i below.
REQ-018 Mode 2: out_data = cnt ^ (cnt >> 1); cnt (WIDTH bits) increments by 1 per accept, wrapping 2^WIDTH-1 -> 0.
REQ-019 Mode 3: out_data = gray2bin(in_data); out_err = prev_valid && (popcount(in_data ^ prev) != 1); then prev <= in_data, prev_valid <= 1.
REQ-020 Repeated identical gray input in mode 3 (distance 0) SHALL flag out_err=1.
REQ-021 clr without accept: cnt <= 0, prev_valid <= 0.
REQ-022 clr with mode-2 accept: output gray(0), cnt <= 1.
REQ-023 clr with mode-3 accept: sample treated as first (out_err=0), prev <= in_data, prev_valid <= 1.
REQ-024 Accepts in modes 0/1 SHALL leave cnt and prev unchanged; mode changes between accepts SHALL NOT reset cnt or prev.
REQ-025 out_err SHALL be 0 for every result produced in modes 0, 1, 2.

Reset
REQ-026 rst_n=0 at an edge: out_valid=0, out_data=0, out_err=0, cnt=0, prev=0, prev_valid=0; in_ready=1 after.
REQ-027 Reset mid-transfer SHALL discard any pending output; rst_n has priority over accept and clr.

Structure
REQ-028 Package gray_pkg SHALL hold mode localparams (MODE_B2G, MODE_G2B, MODE_CNT, MODE_CHK) and functions bin2gray and gray2bin.
REQ-029 One sub-module gray_step_check (WIDTH-parametrised; inputs cur, prev, prev_valid; output err) SHALL implement REQ-019 error logic.

Verification (WIDTH=4)
REQ-030 Mode 0, in_data=1011, out_ready=1 -> next cycle out_data=1110, out_err=0.
REQ-031 Mode 1, in_data=1110 -> out_data=1011; all 16 codes round-trip through modes 0 then 1.
REQ-032 Mode 2, 17 accepts after reset -> 0000,0001,0011,0010,...,1000, then 0000 (wrap); clr mid-sequence -> next output 0000.
REQ-033 Mode 3, inputs 0000,0001,0011,0111,0100,0100 -> out_err 0,0,0,0,1,1; clr then 1111 -> out_err 0.
REQ-034 out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0, out_data stable, no input lost; release -> results in order.
REQ-035 rst_n=0 with out_valid=1 and cnt=5 -> after edge out_valid=0, out_data=0; next mode-2 accept gives 0000.
